// File: rtl/jelly3_video_pkg.sv
// jelly3_video_pkg: shared video counter types and capture state encoding
package jelly3_video_pkg;
  typedef logic [11:0] width_t;
  typedef logic [11:0] height_t;
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT_SOF, ST_ACTIVE, ST_DROP} st_t;
endpackage

// File: rtl/jelly3_axi4s_if.sv
// jelly3_axi4s_if: AXI4-Stream video interface (tuser[0] = start of frame)
interface jelly3_axi4s_if #(
  parameter int DATA_BITS = 8,
  parameter int USER_BITS = 1
);
  logic                 tvalid;
  logic                 tready;
  logic                 tlast;
  logic [USER_BITS-1:0] tuser;
  logic [DATA_BITS-1:0] tdata;
  modport m (output tvalid, tdata, tuser, tlast, input tready);
  modport s (input tvalid, tdata, tuser, tlast, output tready);
endinterface

// File: rtl/jelly3_video_sync_to_axi4s_fifo.sv
// jelly3_video_sync_to_axi4s_fifo: first-word-fall-through FIFO, 2**PTR_BITS entries
module jelly3_video_sync_to_axi4s_fifo #(
  parameter int DATA_BITS = 10,
  parameter int PTR_BITS  = 5
)(
  input  logic                 aresetn,
  input  logic                 aclk,
  input  logic                 wr_en,
  input  logic [DATA_BITS-1:0] wr_data,
  input  logic                 rd_en,
  output logic [DATA_BITS-1:0] rd_data,
  output logic                 full,
  output logic                 empty
);
  logic [DATA_BITS-1:0] mem_q [2**PTR_BITS];
  logic [PTR_BITS:0]    wr_ptr_q, rd_ptr_q;
  assign empty   = wr_ptr_q == rd_ptr_q;
  assign full    = wr_ptr_q == {~rd_ptr_q[PTR_BITS], rd_ptr_q[PTR_BITS-1:0]};
  assign rd_data = mem_q[rd_ptr_q[PTR_BITS-1:0]];
  always_ff @(posedge aclk)
    if (wr_en) mem_q[wr_ptr_q[PTR_BITS-1:0]] <= wr_data;
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + (PTR_BITS+1)'(1);
      if (rd_en) rd_ptr_q <= rd_ptr_q + (PTR_BITS+1)'(1);
    end
endmodule

// File: rtl/jelly3_video_sync_to_axi4s.sv
// jelly3_video_sync_to_axi4s: parallel vsync/de video to frame-aligned AXI4-Stream.
// Measurement counters are built only with JELLY3_VIDEO_SYNC_TO_AXI4S_MEASURE_EN.
module jelly3_video_sync_to_axi4s #(
  parameter type width_t       = jelly3_video_pkg::width_t,
  parameter type height_t      = jelly3_video_pkg::height_t,
  parameter int  FIFO_PTR_BITS = 5,
  parameter bit  VSYNC_POL     = 1'b1,
  parameter int  DATA_BITS     = 8
)(
  input  logic                 aresetn,
  input  logic                 aclk,
  input  logic                 aclken,
  input  logic                 in_vsync,
  input  logic                 in_de,
  input  logic [DATA_BITS-1:0] in_data,
  jelly3_axi4s_if.m            m_axi4s,
  input  logic                 ctl_enable,
  output logic                 ctl_busy,
  input  logic                 ctl_clear,
  output logic                 err_overflow,
  output width_t               meas_width,
  output height_t              meas_height,
  output logic                 meas_valid
);
  import jelly3_video_pkg::*;
  st_t                  state_q;
  logic                 vsync_q, stg_valid_q, stg_sof_q, err_q;
  logic [DATA_BITS-1:0] stg_data_q;
  logic                 vs_edge, cap, rd, wr_req, wr_last, ovf, fifo_wr, load, full, empty;
  logic [DATA_BITS+1:0] rd_data;
  assign vs_edge = aclken && in_vsync == VSYNC_POL && vsync_q != VSYNC_POL;
  assign cap     = state_q == ST_WAIT_SOF || state_q == ST_ACTIVE;
  assign rd      = aclken && !empty && m_axi4s.tready;
  // A valid stage is written every enabled cycle: mid-line when the next pixel
  // arrives, or as end of line when de drops or vsync forces a flush.
  assign wr_req  = aclken && cap && stg_valid_q;
  assign wr_last = vs_edge || !in_de;
  assign ovf     = wr_req && full && !rd;
  assign fifo_wr = wr_req && !ovf;
  assign load    = aclken && cap && in_de && !vs_edge && !ovf;
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      state_q     <= ST_IDLE;
      vsync_q     <= 1'b0;
      stg_valid_q <= 1'b0;
      stg_sof_q   <= 1'b0;
      stg_data_q  <= '0;
      err_q       <= 1'b0;
    end else if (aclken) begin
      vsync_q     <= in_vsync;
      state_q     <= vs_edge ? (ctl_enable ? ST_WAIT_SOF : ST_IDLE) :
                     ovf ? ST_DROP :
                     (state_q == ST_WAIT_SOF && in_de) ? ST_ACTIVE : state_q;
      stg_valid_q <= load;
      if (load) begin
        stg_sof_q  <= state_q == ST_WAIT_SOF;
        stg_data_q <= in_data;
      end
      err_q       <= ovf || (err_q && !ctl_clear);
    end
  jelly3_video_sync_to_axi4s_fifo #(
    .DATA_BITS (DATA_BITS + 2),
    .PTR_BITS  (FIFO_PTR_BITS)
  ) u_fifo (
    .aresetn (aresetn),
    .aclk    (aclk),
    .wr_en   (fifo_wr),
    .wr_data ({stg_sof_q, wr_last, stg_data_q}),
    .rd_en   (rd),
    .rd_data (rd_data),
    .full    (full),
    .empty   (empty)
  );
  assign m_axi4s.tvalid = !empty;
  assign m_axi4s.tdata  = rd_data[DATA_BITS-1:0];
  assign m_axi4s.tlast  = rd_data[DATA_BITS];
  always_comb begin
    m_axi4s.tuser    = '0;
    m_axi4s.tuser[0] = rd_data[DATA_BITS+1];
  end
  assign ctl_busy     = state_q != ST_IDLE;
  assign err_overflow = err_q;
`ifdef JELLY3_VIDEO_SYNC_TO_AXI4S_MEASURE_EN
  width_t  pix_cnt_q, line_w_q, line_w_d, meas_width_q;
  height_t line_cnt_q, line_cnt_d, meas_height_q;
  logic    meas_valid_q, line_end, latch;
  assign line_end   = fifo_wr && wr_last;
  assign line_cnt_d = line_end && line_cnt_q != '1 ? line_cnt_q + height_t'(1) : line_cnt_q;
  assign line_w_d   = line_end ? pix_cnt_q : line_w_q;
  assign latch      = vs_edge && (state_q == ST_ACTIVE || state_q == ST_DROP);
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      pix_cnt_q     <= '0;
      line_w_q      <= '0;
      line_cnt_q    <= '0;
      meas_width_q  <= '0;
      meas_height_q <= '0;
      meas_valid_q  <= 1'b0;
    end else if (aclken) begin
      if (load) pix_cnt_q <= !stg_valid_q ? width_t'(1) : pix_cnt_q == '1 ? pix_cnt_q : pix_cnt_q + width_t'(1);
      line_cnt_q   <= vs_edge ? '0 : line_cnt_d;
      line_w_q     <= vs_edge ? '0 : line_w_d;
      meas_valid_q <= latch;
      if (latch) begin
        meas_width_q  <= line_w_d;
        meas_height_q <= line_cnt_d;
      end
    end
  assign meas_width  = meas_width_q;
  assign meas_height = meas_height_q;
  assign meas_valid  = meas_valid_q;
`else
  assign meas_width  = '0;
  assign meas_height = '0;
  assign meas_valid  = 1'b0;
`endif
endmodule

// File: tb/tb_jelly3_video_sync_to_axi4s.sv
// tb_jelly3_video_sync_to_axi4s: frame-level scoreboard bench for the sync-to-AXI4S bridge
module tb_jelly3_video_sync_to_axi4s;
  localparam int DW = 8;
`ifdef JELLY3_VIDEO_SYNC_TO_AXI4S_MEASURE_EN
  localparam bit MEAS = 1'b1;
`else
  localparam bit MEAS = 1'b0;
`endif
  typedef logic [DW+2:0] beat_t;
  logic          aclk = 0, aresetn = 0, aclken = 1, in_vsync = 0, in_de = 0;
  logic          ctl_enable = 0, ctl_clear = 0;
  logic [DW-1:0] in_data = '0;
  logic          ctl_busy, err_overflow, meas_valid;
  logic [11:0]   meas_width, meas_height;
  int            n_chk = 0, n_fail = 0;
  bit            rnd_ready = 0, stall_en = 0, sof_pend = 0;
  beat_t         exp_q[$], got_q[$];
  jelly3_axi4s_if #(.DATA_BITS(DW), .USER_BITS(2)) axi ();
  jelly3_video_sync_to_axi4s #(.FIFO_PTR_BITS(5), .VSYNC_POL(1'b1), .DATA_BITS(DW)) dut (
    .aresetn      (aresetn),
    .aclk         (aclk),
    .aclken       (aclken),
    .in_vsync     (in_vsync),
    .in_de        (in_de),
    .in_data      (in_data),
    .m_axi4s      (axi),
    .ctl_enable   (ctl_enable),
    .ctl_busy     (ctl_busy),
    .ctl_clear    (ctl_clear),
    .err_overflow (err_overflow),
    .meas_width   (meas_width),
    .meas_height  (meas_height),
    .meas_valid   (meas_valid)
  );
  always #5 aclk = ~aclk;
  always @(negedge aclk)
    if (aresetn && aclken && axi.tvalid && axi.tready) got_q.push_back({axi.tuser, axi.tlast, axi.tdata});
  task automatic chk(string tag, int got, int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  function automatic beat_t mk(bit s, bit l, logic [DW-1:0] d);
    return {1'b0, s, l, d};
  endfunction
  task automatic step();
    @(posedge aclk);
    #1;
  endtask
  task automatic cyc(logic vs, logic de, logic [DW-1:0] d);
    if (stall_en)
      while ($urandom_range(7) == 0) begin
        aclken   = 0;
        in_vsync = 1'($urandom);
        in_de    = 1'($urandom);
        in_data  = DW'($urandom);
        if (rnd_ready) axi.tready = $urandom_range(3) != 0;
        step();
      end
    aclken   = 1;
    in_vsync = vs;
    in_de    = de;
    in_data  = d;
    if (rnd_ready) axi.tready = $urandom_range(3) != 0;
    step();
  endtask
  task automatic vs(bit de = 0);
    sof_pend = 1;
    cyc(1, de, DW'($urandom));
  endtask
  task automatic line(int w, int gap, bit ex);
    for (int x = 0; x < w; x++) begin
      logic [DW-1:0] d;
      d = DW'($urandom);
      if (ex) exp_q.push_back(mk(sof_pend, x == w - 1, d));
      sof_pend = 0;
      cyc(0, 1, d);
    end
    repeat (gap) cyc(0, 0, '0);
  endtask
  task automatic lines(int w, int h, bit ex);
    repeat (h) line(w, 3, ex);
  endtask
  task automatic drain(string tag);
    int n = 0;
    while (got_q.size() < exp_q.size() && n < 400) begin
      cyc(0, 0, '0);
      n++;
    end
    repeat (6) cyc(0, 0, '0);
    chk({tag, " count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("%s beat%0d", tag, i), got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask
  initial begin
    int pw, ph;
    axi.tready = 1;
    repeat (3) step();
    chk("rst tvalid", axi.tvalid, 0);
    chk("rst busy", ctl_busy, 0);
    chk("rst err", err_overflow, 0);
    chk("rst mw", meas_width, 0);
    chk("rst mh", meas_height, 0);
    chk("rst mv", meas_valid, 0);
    aresetn = 1;
    step();
    // 4x3 frame, measured at the following vsync
    ctl_enable = 1;
    vs();
    chk("t1 busy", ctl_busy, 1);
    chk("t1 mv idle", meas_valid, 0);
    lines(4, 3, 1);
    vs();
    chk("t1 mv", meas_valid, MEAS);
    chk("t1 mw", meas_width, MEAS ? 4 : 0);
    chk("t1 mh", meas_height, MEAS ? 3 : 0);
    cyc(0, 0, '0);
    chk("t1 mv pulse", meas_valid, 0);
    drain("t1");
    // capture disabled at the edge; enable mid-frame has no effect
    ctl_enable = 0;
    vs();
    chk("t2 mv wait", meas_valid, 0);
    chk("t2 busy", ctl_busy, 0);
    lines(4, 1, 0);
    ctl_enable = 1;
    lines(4, 2, 0);
    drain("t2 off");
    chk("t2 busy off", ctl_busy, 0);
    vs();
    chk("t2 mv idle", meas_valid, 0);
    lines(3, 2, 1);
    drain("t2 on");
    // overflow with clear coincident on the overflow cycle
    axi.tready = 0;
    vs();
    for (int i = 0; i < 64; i++) begin
      logic [DW-1:0] d;
      d = DW'($urandom);
      if (i < 32) exp_q.push_back(mk(i == 0, 0, d));
      ctl_clear = i == 33;
      cyc(0, 1, d);
      if (i == 32) chk("t3 err pre", err_overflow, 0);
      if (i == 33) chk("t3 err set+clr", err_overflow, 1);
    end
    ctl_clear = 0;
    repeat (3) cyc(0, 0, '0);
    chk("t3 err", err_overflow, 1);
    chk("t3 tvalid", axi.tvalid, 1);
    chk("t3 busy", ctl_busy, 1);
    axi.tready = 1;
    lines(4, 1, 0);
    drain("t3");
    ctl_clear = 1;
    cyc(0, 0, '0);
    ctl_clear = 0;
    chk("t3 err clr", err_overflow, 0);
    vs();
    chk("t3 mv drop", meas_valid, MEAS);
    chk("t3 mh drop", meas_height, 0);
    lines(5, 2, 1);
    drain("t3 next");
    // vsync coincident with de while a pixel is pending
    vs();
    lines(3, 1, 1);
    line(4, 0, 1);
    vs(1);
    chk("t4 mw", meas_width, MEAS ? 4 : 0);
    chk("t4 mh", meas_height, MEAS ? 2 : 0);
    lines(2, 2, 1);
    drain("t4");
    // asynchronous reset mid-line with data waiting
    axi.tready = 0;
    vs();
    line(6, 0, 0);
    chk("t5 tvalid pre", axi.tvalid, 1);
    #2 aresetn = 0;
    #1;
    chk("t5 tvalid rst", axi.tvalid, 0);
    chk("t5 busy rst", ctl_busy, 0);
    step();
    aresetn = 1;
    axi.tready = 1;
    line(4, 3, 0);
    drain("t5 idle");
    chk("t5 tvalid idle", axi.tvalid, 0);
    vs();
    chk("t5 mv idle", meas_valid, 0);
    lines(3, 2, 1);
    drain("t5 resume");
    // random geometry, backpressure and clock-enable stalls
    rnd_ready = 1;
    stall_en  = 1;
    pw = 3;
    ph = 2;
    for (int f = 0; f < 5; f++) begin
      int w, h;
      w = $urandom_range(2, 8);
      h = $urandom_range(1, 4);
      vs();
      chk($sformatf("rand%0d mv", f), meas_valid, MEAS);
      chk($sformatf("rand%0d mw", f), meas_width, MEAS ? pw : 0);
      chk($sformatf("rand%0d mh", f), meas_height, MEAS ? ph : 0);
      lines(w, h, 1);
      pw = w;
      ph = h;
    end
    drain("rand");
    chk("rand err", err_overflow, 0);
    rnd_ready = 0;
    stall_en  = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
